// File: rtl/dac_spi_tx.sv
// dac_spi_tx -- serial transmitter for a 16-bit DAC frame {CMD, data}.
//
// Each frame: chip select falls, CLK_DIV cycles of setup, then 16 bits MSB
// first (sclk low for CLK_DIV cycles, then high for CLK_DIV cycles per bit).
// After that come CLK_DIV cycles of hold with sclk low. Chip select then
// rises and done pulses for one cycle. Chip select is low for 34*CLK_DIV
// cycles per frame.
//
// Parameters
//   CLK_DIV  sclk half-period in clk cycles (2..255)
//   CMD      command nibble sent ahead of the 12-bit sample
// Ports
//   clk      master clock
//   rst_n    asynchronous active-low reset
//   enb      enable; low aborts any transfer and holds the block idle
//   start    one-cycle send request, taken only when idle and enabled
//   data     12-bit sample, captured when a start is accepted
//   sclk     serial clock to the DAC, idle low
//   cs_n     DAC chip select, active low
//   mosi     serial data, MSB first
//   busy     high while a frame is in progress
//   done     one-cycle pulse on normal frame completion
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | cs_n high, waiting for an accepted start
// SETUP | cs_n low, sclk low, first bit on mosi for CLK_DIV cycles
// SHIFT | 16 bits, each a CLK_DIV low phase then a CLK_DIV high phase
// HOLD  | sclk low, cs_n still low for CLK_DIV cycles before release
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CMD     = 4'b0011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enb,
  input  logic        start,
  input  logic [11:0] data,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] frame, frame_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  div_cnt, div_cnt_nxt;
  logic        sclk_nxt, cs_n_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic        div_tc;

  assign div_tc = (div_cnt == DIV_LAST);

  // Every output is the registered version of its *_nxt value, so nothing
  // combinational reaches a pin. The frame is held unshifted; bit_cnt picks
  // the bit on mosi (bit 15 first).
  always_comb begin
    state_nxt   = state;
    frame_nxt   = frame;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    sclk_nxt    = sclk;
    cs_n_nxt    = cs_n;
    mosi_nxt    = mosi;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        cs_n_nxt = 1'b1;
        sclk_nxt = 1'b0;
        mosi_nxt = 1'b0;
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt   = SETUP;
          frame_nxt   = {CMD, data};
          bit_cnt_nxt = 5'd0;
          div_cnt_nxt = 8'd0;
          cs_n_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          mosi_nxt    = CMD[3];
        end
      end

      SETUP: begin
        if (div_tc) begin
          state_nxt   = SHIFT;
          div_cnt_nxt = 8'd0;
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      SHIFT: begin
        if (div_tc) begin
          div_cnt_nxt = 8'd0;
          if (!sclk) begin
            sclk_nxt = 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            // mosi keeps the last bit through HOLD
            state_nxt = HOLD;
            sclk_nxt  = 1'b0;
          end else begin
            // next bit goes out on the falling edge only
            bit_cnt_nxt = bit_cnt + 5'd1;
            sclk_nxt    = 1'b0;
            mosi_nxt    = frame[~bit_cnt_nxt[3:0]];
          end
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      HOLD: begin
        if (div_tc) begin
          state_nxt   = IDLE;
          div_cnt_nxt = 8'd0;
          cs_n_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          mosi_nxt    = 1'b0;
          done_nxt    = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Disable wins over everything: drop the frame silently, no done.
    if (!enb) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 5'd0;
      div_cnt_nxt = 8'd0;
      cs_n_nxt    = 1'b1;
      sclk_nxt    = 1'b0;
      mosi_nxt    = 1'b0;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      frame   <= 16'd0;
      bit_cnt <= 5'd0;
      div_cnt <= 8'd0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      frame   <= frame_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
      sclk    <= sclk_nxt;
      cs_n    <= cs_n_nxt;
      mosi    <= mosi_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Testbench for dac_spi_tx: one instance with CLK_DIV=4 and one with
// CLK_DIV=2. The expected frame is computed as {CMD, data}. What the DAC
// receives is rebuilt by sampling mosi on every rising sclk edge, and
// chip-select timing is measured against 34*CLK_DIV.
module tb_dac_spi_tx;

  logic        clk;
  logic        rst_n;
  logic        enb;
  logic        start4, start2;
  logic [11:0] data;
  logic        sclk4, cs_n4, mosi4, busy4, done4;
  logic        sclk2, cs_n2, mosi2, busy2, done2;
  logic        sel;
  logic        sclk, cs_n, mosi, busy, done;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] CMD = 4'b0011;

  dac_spi_tx #(.CLK_DIV(4), .CMD(CMD)) dut4 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .start(start4), .data(data),
    .sclk(sclk4), .cs_n(cs_n4), .mosi(mosi4), .busy(busy4), .done(done4)
  );

  dac_spi_tx #(.CLK_DIV(2), .CMD(CMD)) dut2 (
    .clk(clk), .rst_n(rst_n), .enb(enb), .start(start2), .data(data),
    .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .busy(busy2), .done(done2)
  );

  assign sclk = sel ? sclk2 : sclk4;
  assign cs_n = sel ? cs_n2 : cs_n4;
  assign mosi = sel ? mosi2 : mosi4;
  assign busy = sel ? busy2 : busy4;
  assign done = sel ? done2 : done4;

  initial clk = 1'b0;
  always #8 clk = ~clk;

  task automatic set_start(input logic v);
    if (sel) start2 = v;
    else     start4 = v;
  endtask

  task automatic send(input logic [11:0] d);
    @(negedge clk);
    set_start(1'b1);
    data = d;
    @(negedge clk);
    set_start(1'b0);
  endtask

  // Called at the first negedge after the accepting clock edge.
  // poke: extra starts at cycles 10 and 50. abort_at / rst_at: drop enb or
  // assert reset in that cycle (0 = never). chain: raise start on done.
  task automatic observe(input logic [11:0] d, input int div, input bit poke,
                         input int abort_at, input int rst_at,
                         input bit chain, input logic [11:0] chain_d);
    logic [15:0] exp_frame;
    logic [15:0] got;
    int          nbits, low, cyc, last_rise;
    logic        prev_sclk, prev_mosi;
    exp_frame = {CMD, d};
    got = 16'd0; nbits = 0; low = 0; cyc = 1; last_rise = 0;
    prev_sclk = 1'b0; prev_mosi = 1'b0;

    checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL cs_assert cs_n=%b busy=%b required cs_n=0 busy=1", cs_n, busy);
    end
    checks++;
    if (mosi !== exp_frame[15]) begin
      failures++;
      $display("FAIL setup_mosi got=%b required=%b", mosi, exp_frame[15]);
    end

    while (cs_n === 1'b0 && cyc <= 40 * div) begin
      low++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL busy_during cyc=%0d busy=%b done=%b required 1/0", cyc, busy, done);
      end
      if (cyc > 1 && mosi !== prev_mosi && !(prev_sclk === 1'b1 && sclk === 1'b0)) begin
        failures++;
        $display("FAIL mosi_stable cyc=%0d mosi changed without sclk fall", cyc);
      end
      if (prev_sclk === 1'b0 && sclk === 1'b1) begin
        got = {got[14:0], mosi};
        nbits++;
        checks++;
        if (nbits == 1) begin
          if (cyc != 2 * div + 1) begin
            failures++;
            $display("FAIL first_rise cyc=%0d required=%0d", cyc, 2 * div + 1);
          end
        end else if (cyc - last_rise != 2 * div) begin
          failures++;
          $display("FAIL sclk_period got=%0d required=%0d", cyc - last_rise, 2 * div);
        end
        last_rise = cyc;
      end
      prev_sclk = sclk;
      prev_mosi = mosi;

      if (cyc == abort_at) begin
        enb = 1'b0;
        @(negedge clk);
        checks++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0) begin
          failures++;
          $display("FAIL enb_abort cs_n=%b sclk=%b busy=%b mosi=%b required 1/0/0/0",
                   cs_n, sclk, busy, mosi);
        end
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (done !== 1'b0 || cs_n !== 1'b1) begin
            failures++;
            $display("FAIL enb_no_done done=%b cs_n=%b required 0/1", done, cs_n);
          end
          @(negedge clk);
        end
        enb = 1'b1;
        return;
      end

      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #2;
        checks++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL async_reset cs_n=%b sclk=%b busy=%b mosi=%b done=%b required 1/0/0/0/0",
                   cs_n, sclk, busy, mosi, done);
        end
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checks++;
          if (done !== 1'b0 || cs_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_no_done done=%b cs_n=%b required 0/1", done, cs_n);
          end
        end
        rst_n = 1'b1;
        return;
      end

      if (poke && (cyc == 10 || cyc == 50)) begin
        set_start(1'b1);
        data = ~d;
      end else begin
        set_start(1'b0);
        data = 12'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    set_start(1'b0);

    checks++;
    if (cs_n !== 1'b1) begin
      failures++;
      $display("FAIL timeout cs_n still low after %0d cycles", cyc);
    end
    checks++;
    if (low != 34 * div) begin
      failures++;
      $display("FAIL cs_low_len got=%0d required=%0d", low, 34 * div);
    end
    checks++;
    if (nbits != 16 || got !== exp_frame) begin
      failures++;
      $display("FAIL payload got=%h (%0d bits) required=%h", got, nbits, exp_frame);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b busy=%b required 1/0", done, busy);
    end

    if (chain) begin
      set_start(1'b1);
      data = chain_d;
      @(negedge clk);
      set_start(1'b0);
    end else begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cs_n !== 1'b1) begin
        failures++;
        $display("FAIL done_width done=%b cs_n=%b required 0/1", done, cs_n);
      end
    end
  endtask

  task automatic test_reset();
    #20;
    checks++;
    if ({sclk4, cs_n4, mosi4, busy4, done4} !== 5'b01000 ||
        {sclk2, cs_n2, mosi2, busy2, done2} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_state div4=%b div2=%b required 01000",
               {sclk4, cs_n4, mosi4, busy4, done4}, {sclk2, cs_n2, mosi2, busy2, done2});
    end
  endtask

  task automatic test_first_frame();
    sel = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    start4 = 1'b1;
    data   = 12'hABC;
    @(negedge clk);
    start4 = 1'b0;
    observe(12'hABC, 4, 1'b0, 0, 0, 1'b0, 12'h000);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    send(12'hFFF);
    observe(12'hFFF, 4, 1'b0, 0, 0, 1'b1, 12'h000);
    observe(12'h000, 4, 1'b0, 0, 0, 1'b0, 12'h000);
  endtask

  task automatic test_ignored_start();
    logic [11:0] d;
    sel = 1'b0;
    d = 12'($urandom);
    send(d);
    observe(d, 4, 1'b1, 0, 0, 1'b0, 12'h000);
  endtask

  task automatic test_enb_abort();
    logic [11:0] d;
    sel = 1'b0;
    d = 12'($urandom);
    send(d);
    observe(d, 4, 1'b0, 60, 0, 1'b0, 12'h000);
    d = 12'($urandom);
    send(d);
    observe(d, 4, 1'b0, 0, 0, 1'b0, 12'h000);
  endtask

  task automatic test_enb_start_ignored();
    sel = 1'b0;
    @(negedge clk);
    enb    = 1'b0;
    start4 = 1'b1;
    data   = 12'h123;
    @(negedge clk);
    start4 = 1'b0;
    enb    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy4 !== 1'b0 || cs_n4 !== 1'b1) begin
        failures++;
        $display("FAIL enb_low_start busy=%b cs_n=%b required 0/1", busy4, cs_n4);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    logic [11:0] d;
    sel = 1'b0;
    d = 12'($urandom);
    send(d);
    observe(d, 4, 1'b0, 0, 30, 1'b0, 12'h000);
    d = 12'($urandom);
    send(d);
    observe(d, 4, 1'b0, 0, 0, 1'b0, 12'h000);
  endtask

  task automatic test_div2();
    sel = 1'b1;
    send(12'h50A);
    observe(12'h50A, 2, 1'b0, 0, 0, 1'b0, 12'h000);
  endtask

  task automatic test_random();
    logic [11:0] d, d2;
    for (int i = 0; i < 6; i++) begin
      sel = i[0];
      d  = 12'($urandom);
      d2 = 12'($urandom);
      send(d);
      observe(d, sel ? 2 : 4, 1'($urandom_range(0, 1)), 0, 0, 1'b1, d2);
      observe(d2, sel ? 2 : 4, 1'b0, 0, 0, 1'b0, 12'h000);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enb    = 1'b1;
    start4 = 1'b0;
    start2 = 1'b0;
    data   = 12'h000;
    sel    = 1'b0;
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_ignored_start();
    test_enb_abort();
    test_enb_start_ignored();
    test_reset_abort();
    test_div2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CMD, default 4'b0011: DAC command nibble sent ahead of the sample.
REQ-003 clk  input  1  16 ns master clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enb  input  1  active-high enable; low aborts any transfer and holds the block idle.
REQ-006 start  input  1  one-cycle request to send data; ignored unless idle and enb=1.
REQ-007 data  input  12  sample (ramp output), captured only on an accepted start.
REQ-008 sclk  output  1  serial clock to the DAC, idle low.
REQ-009 cs_n  output  1  DAC chip select, active low.
REQ-010 mosi  output  1  serial data, MSB first.
REQ-011 busy  output  1  high while a transfer is in progress.
REQ-012 done  output  1  one-cycle pulse on normal transfer completion.

Function
REQ-013 All outputs SHALL be driven directly from flops; no combinational paths from inputs to outputs.
REQ-014 FSM states SHALL be IDLE, SETUP, SHIFT and HOLD.
REQ-015 IDLE outputs SHALL be cs_n=1, sclk=0, mosi=0 and busy=0.
REQ-016 A start accepted at clock edge N SHALL load the 16-bit frame {CMD, data} and enter SETUP, with cs_n=0 and busy=1 from cycle N+1.
REQ-017 SETUP SHALL last CLK_DIV cycles with sclk=0 and mosi=frame[15].
REQ-018 SHIFT SHALL send bits 15 down to 0, each held on mosi for 2*CLK_DIV cycles: sclk low for the first CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-019 mosi SHALL change only in the cycle sclk falls (or on SETUP entry), so data is stable across each rising sclk edge.
REQ-020 After the high phase of bit 0, the FSM SHALL enter HOLD: sclk=0, cs_n=0 for CLK_DIV cycles.
REQ-021 On leaving HOLD, the FSM SHALL return to IDLE (cs_n=1, busy=0) and assert done for exactly one cycle.
REQ-022 cs_n low time SHALL be exactly 34*CLK_DIV cycles per normal transfer.
REQ-023 A start asserted in the same cycle done is high SHALL be accepted, giving back-to-back frames with cs_n high for exactly 1 cycle.
REQ-024 A start while busy=1 SHALL be ignored, with no queuing; data changes while busy SHALL NOT affect the frame in flight.
REQ-025 If enb=0 in any cycle, the next cycle SHALL show IDLE outputs, with the transfer discarded and no done pulse.
REQ-026 start with enb=0 in the same cycle SHALL be ignored.
REQ-027 The bit counter (5 bits) and the divider counter (8 bits) SHALL reset to 0 on every entry to SETUP.

Reset
REQ-028 While rst_n=0: state=IDLE; sclk=0, cs_n=1, mosi=0, busy=0, done=0; shift register and counters cleared.
REQ-029 rst_n asserted mid-transfer SHALL abort immediately (asynchronously) with no done pulse.
REQ-030 The first start is accepted at the first clk edge after rst_n deasserts, provided enb=1.

Verification
REQ-031 CLK_DIV=4, CMD=0011, enb=1, start with data=12'hABC at edge 0 -> mosi sampled on 16 sclk rises = 0011_1010_1011_1100; cs_n low cycles 1..136; done=1 at cycle 137 only.
REQ-032 data=12'hFFF, then start held high on the done cycle with data=12'h000 -> second frame begins immediately; cs_n high exactly 1 cycle; second frame payload = 0011_0000_0000_0000.
REQ-033 start pulsed at cycles 10 and 50 of a transfer with different data -> both ignored; the frame sent matches the original data; exactly one done pulse.
REQ-034 enb dropped at cycle 60 of a transfer -> cycle 61 shows cs_n=1, sclk=0, busy=0; done never asserted; next start after enb=1 sends a full 136-cycle frame.
REQ-035 rst_n pulsed low during SHIFT -> outputs go to reset values without waiting for clk; no done pulse; normal transfer after release.
REQ-036 CLK_DIV=2 with data=12'h50A -> sclk period 4 cycles; cs_n low 68 cycles; payload = 0011_0101_0000_1010.
